// File: rtl/sd_types_pkg.sv
// Shared SD types for the RK8E SD controller: big-endian bit numbering (bit 0 = MSB),
// framer state encoding and the serial CRC7 helper.
package sd_types;

  typedef logic [0:7]  sdBYTE_t;
  typedef logic [0:47] sdCMD_t;
  typedef logic [0:31] sdDISKaddr_t;
  typedef logic [0:6]  sdCCRC_t;

  typedef enum logic [2:0] {
    IDLE,
    CRC,
    PRE,
    SEND,
    DONE
  } sdFRAMEstate_t;

  localparam sdBYTE_t sdFILL = 8'hFF;

  // CRC7 (x^7 + x^3 + 1), one byte folded in MSB first.
  function automatic sdCCRC_t crc7(input sdBYTE_t data, input sdCCRC_t crc);
    sdCCRC_t c;
    logic    fb;
    c = crc;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = data[i] ^ c[0];
      c  = {c[1:6], 1'b0};
      if (fb) c = c ^ 7'b0001001;
    end
    return c;
  endfunction

endpackage

// File: rtl/sd_cmd_framer.sv
// SPI-mode SD command framer: builds the 6-byte command frame with a serial CRC7 and
// streams NPRE fill bytes plus the frame to the SPI byte engine over valid/ready.
module sd_cmd_framer
  import sd_types::*;
#(
  parameter int unsigned NPRE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  cmdIDX,
  input  sdDISKaddr_t cmdARG,
  input  logic        abort,
  output sdBYTE_t     txDATA,
  output logic        txVALID,
  input  logic        txREADY,
  output logic        busy,
  output logic        done,
  output sdCMD_t      frame
);

  localparam logic [3:0] LAST_FILL = (NPRE == 0) ? 4'd0 : 4'(NPRE - 1);

  sdFRAMEstate_t state, state_next;
  logic [2:0]    idx;
  logic [3:0]    fill;
  sdCCRC_t       crc, crc_next;
  logic [0:39]   hdr;
  sdBYTE_t       hdr_byte, frame_byte;
  logic          xfer;

  assign xfer     = txVALID & txREADY;
  assign crc_next = crc7(hdr_byte, crc);

  always_comb begin
    case (idx)
      3'd0:    hdr_byte = hdr[0:7];
      3'd1:    hdr_byte = hdr[8:15];
      3'd2:    hdr_byte = hdr[16:23];
      3'd3:    hdr_byte = hdr[24:31];
      default: hdr_byte = hdr[32:39];
    endcase
  end

  always_comb begin
    case (idx)
      3'd0:    frame_byte = frame[0:7];
      3'd1:    frame_byte = frame[8:15];
      3'd2:    frame_byte = frame[16:23];
      3'd3:    frame_byte = frame[24:31];
      3'd4:    frame_byte = frame[32:39];
      default: frame_byte = frame[40:47];
    endcase
  end

  always_comb begin
    state_next = state;
    txVALID    = 1'b0;
    txDATA     = sdFILL;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = CRC;
      CRC: begin
        busy = 1'b1;
        if (idx == 3'd4) state_next = (NPRE == 0) ? SEND : PRE;
      end
      PRE: begin
        busy    = 1'b1;
        txVALID = 1'b1;
        if (xfer && fill == LAST_FILL) state_next = SEND;
      end
      SEND: begin
        busy    = 1'b1;
        txVALID = 1'b1;
        txDATA  = frame_byte;
        if (xfer && idx == 3'd5) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? CRC : IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      fill  <= '0;
      crc   <= '0;
      hdr   <= '0;
      frame <= '0;
    end else begin
      state <= state_next;
      // Datapath is frozen on abort so a cancelled CRC pass never overwrites frame.
      if (!abort) begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              hdr <= {2'b01, cmdIDX, cmdARG};
              crc <= '0;
              idx <= '0;
            end
          end
          CRC: begin
            crc <= crc_next;
            if (idx == 3'd4) begin
              frame <= {hdr, crc_next, 1'b1};
              idx   <= '0;
              fill  <= '0;
            end else begin
              idx <= idx + 3'd1;
            end
          end
          PRE:  if (xfer) fill <= fill + 4'd1;
          SEND: if (xfer) idx <= idx + 3'd1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_cmd_framer.sv
// Bench for sd_cmd_framer: two instances (NPRE=1 and NPRE=0) share stimulus and are
// checked against a polynomial-division CRC7 frame model and cycle-latency rules.
module tb_sd_cmd_framer;

  localparam int NPRE_A = 1;
  localparam int NPRE_B = 0;

  logic        clk = 1'b0;
  logic        reset, start, abort, ready;
  logic [5:0]  idx;
  logic [31:0] arg;
  logic [7:0]  data_a, data_b;
  logic        valid_a, valid_b, busy_a, busy_b, done_a, done_b;
  logic [47:0] frame_a, frame_b;

  always #5 clk = ~clk;

  sd_cmd_framer #(.NPRE(NPRE_A)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .cmdIDX(idx), .cmdARG(arg), .abort(abort),
    .txDATA(data_a), .txVALID(valid_a), .txREADY(ready), .busy(busy_a), .done(done_a),
    .frame(frame_a)
  );

  sd_cmd_framer #(.NPRE(NPRE_B)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .cmdIDX(idx), .cmdARG(arg), .abort(abort),
    .txDATA(data_b), .txVALID(valid_b), .txREADY(ready), .busy(busy_b), .done(done_b),
    .frame(frame_b)
  );

  logic        mv[2], mbusy[2], mdone[2];
  logic [7:0]  md[2];
  logic [47:0] mframe[2];
  assign mv[0] = valid_a;     assign mv[1] = valid_b;
  assign mbusy[0] = busy_a;   assign mbusy[1] = busy_b;
  assign mdone[0] = done_a;   assign mdone[1] = done_b;
  assign md[0] = data_a;      assign md[1] = data_b;
  assign mframe[0] = frame_a; assign mframe[1] = frame_b;

  typedef logic [7:0] byteq_t[$];

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          t0 = 0;
  int          mode = 0;
  int          npre[2] = '{NPRE_A, NPRE_B};
  logic        armed[2], done_seen[2], prev_wait[2];
  int          stalls[2], first_valid[2];
  logic [7:0]  prev_data[2];
  byteq_t      got_q[2], exp_q[2];
  logic [47:0] exp_frame;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame = {01, index, argument, CRC7, 1}; CRC7 as the remainder of msg*x^7 mod x^7+x^3+1.
  function automatic logic [47:0] model(input logic [5:0] i, input logic [31:0] a);
    logic [39:0] msg;
    logic [46:0] r;
    msg = {2'b01, i, a};
    r   = {msg, 7'b0};
    for (int b = 46; b >= 7; b--)
      if (r[b]) r = r ^ (47'h89 << (b - 7));
    return {msg, r[6:0], 1'b1};
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int n;
      n = cyc - t0 + 1;
      if (armed[d]) begin
        if (n == 1) check("busy_cycle1", mbusy[d], 1);
        if (prev_wait[d]) begin
          check("stall_hold_valid", mv[d], 1);
          check("stall_hold_data", md[d], prev_data[d]);
        end
        if (mv[d] && first_valid[d] < 0) begin
          first_valid[d] = n;
          check("first_valid_cycle", n, 6);
        end
        if (mv[d] && ready) got_q[d].push_back(md[d]);
        if (mv[d] && !ready) stalls[d]++;
        prev_wait[d] = mv[d] && !ready;
        prev_data[d] = md[d];
        if (mdone[d]) begin
          check("done_cycle", n, 12 + npre[d] + stalls[d]);
          check("busy_in_done", mbusy[d], 0);
          check("byte_count", got_q[d].size(), exp_q[d].size());
          for (int k = 0; k < got_q[d].size() && k < exp_q[d].size(); k++)
            check("tx_byte", got_q[d][k], exp_q[d][k]);
          check("frame", mframe[d], exp_frame);
          armed[d]     = 1'b0;
          done_seen[d] = 1'b1;
        end
      end else begin
        check("stray_done", mdone[d], 0);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (mode)
      0:       ready = 1'b1;
      1:       ready = ~ready;
      default: ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Called #1 after a rising edge; the next edge is edge 0 of the new command.
  task automatic issue(input logic [5:0] i, input logic [31:0] a);
    idx = i; arg = a; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 6'($urandom); arg = $urandom;
    exp_frame = model(i, a);
    t0 = cyc;
    for (int d = 0; d < 2; d++) begin
      armed[d] = 1'b1; done_seen[d] = 1'b0; prev_wait[d] = 1'b0;
      stalls[d] = 0; first_valid[d] = -1;
      got_q[d].delete(); exp_q[d].delete();
      for (int k = 0; k < npre[d]; k++) exp_q[d].push_back(8'hFF);
      for (int k = 0; k < 6; k++) exp_q[d].push_back(exp_frame[47 - 8*k -: 8]);
    end
  endtask

  task automatic wait_done();
    for (int c = 0; c < 300 && !(done_seen[0] && done_seen[1]); c++) begin
      @(posedge clk); #1;
    end
    check("done_timeout", {done_seen[0], done_seen[1]}, 2'b11);
  endtask

  task automatic disarm();
    for (int d = 0; d < 2; d++) begin
      armed[d] = 1'b0; prev_wait[d] = 1'b0;
    end
  endtask

  task automatic wait_bytes(input int cnt);
    for (int c = 0; c < 100 && got_q[0].size() < cnt; c++) begin
      @(posedge clk); #1;
    end
    check("wait_bytes_timeout", got_q[0].size(), cnt);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1; idx = '0; arg = '0;
    disarm();
    done_seen = '{1'b0, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", data_a, 8'hFF);
    check("rst_valid", valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_frame", frame_a, 48'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    mode = 0;
    issue(6'd0, 32'h0);
    wait_done();
    check("cmd0_crc", frame_a[7:0], 8'h95);

    issue(6'd8, 32'h0000_01AA);
    wait_done();
    check("cmd8_crc", frame_a[7:0], 8'h87);

    // CMD17 then CMD55 with the second start raised in the DONE cycle of the NPRE=1 unit.
    issue(6'd17, 32'h0);
    for (int c = 0; c < 100 && !done_a; c++) begin
      @(posedge clk); #1;
    end
    check("b2b_done_seen", done_a, 1);
    check("cmd17_crc", frame_a[7:0], 8'h55);
    issue(6'd55, 32'h0);
    check("b2b_accept_busy", busy_a, 1);
    wait_done();
    check("cmd55_crc", frame_a[7:0], 8'h65);

    mode = 1;
    issue(6'd8, 32'h0000_01AA);
    wait_done();
    mode = 0;

    // start while busy must be ignored
    issue(6'd9, 32'h1234_5678);
    @(posedge clk); #1;
    idx = 6'd17; arg = 32'hDEAD_BEEF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();

    // abort after three frame bytes of the NPRE=1 unit
    issue(6'd24, 32'h0000_0200);
    wait_bytes(NPRE_A + 3);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    disarm();
    check("abort_valid_a", valid_a, 0);
    check("abort_busy_a", busy_a, 0);
    check("abort_done_a", done_a, 0);
    check("abort_frame_a", frame_a, exp_frame);
    check("abort_valid_b", valid_b, 0);
    repeat (4) @(posedge clk);
    #1;
    issue(6'($urandom), $urandom);
    wait_done();

    // asynchronous reset in the middle of SEND
    issue(6'd41, 32'h4000_0000);
    wait_bytes(NPRE_A + 2);
    #2;
    reset = 1'b1;
    #1;
    disarm();
    check("mrst_data_a", data_a, 8'hFF);
    check("mrst_valid_a", valid_a, 0);
    check("mrst_busy_a", busy_a, 0);
    check("mrst_done_a", done_a, 0);
    check("mrst_frame_a", frame_a, 48'h0);
    check("mrst_valid_b", valid_b, 0);
    check("mrst_frame_b", frame_b, 48'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int r = 0; r < 16; r++) begin
      mode = int'($urandom_range(0, 2));
      issue(6'($urandom), $urandom);
      wait_done();
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    mode = 0;
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
